elastic_pipe_reg: RTL and testbench
===================================

Name: elastic_pipe_reg

Overview:
- Parametrised successor to the single-bit DFF variants: a DEPTH-stage, WIDTH-bit register pipeline with a valid/ready handshake on both sides.
- Bubbles collapse: an empty stage always accepts data, even while the output is stalled.
- A parameter selects whether data flops are reset (the valid flops are always reset).
- Used as a generic retiming/elastic slice between datapath blocks; also reports live occupancy.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 3, number of register stages (>=1); no-stall latency and maximum capacity.
- RST_DATA, 0, 1: data flops clear to 0 on reset; 0: data flops have no reset (valid flops always reset).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush_i  input  1  synchronous pipeline clear (discards all held words).
- in_valid_i  input  1  upstream word valid.
- in_ready_o  output  1  block can accept a word this cycle.
- in_data_i  input  WIDTH  upstream data.
- out_valid_o  output  1  output word valid.
- out_ready_i  input  1  downstream accepts.
- out_data_o  output  WIDTH  output data (= data of stage DEPTH-1).
- count_o  output  $clog2(DEPTH+1)  number of valid words held.

Behaviour:
- State: valid_q[k] and data_q[k] for k = 0..DEPTH-1; stage 0 is the input side, stage DEPTH-1 drives the outputs.
- Ready chain (combinational):
  - rdy[DEPTH] = out_ready_i.
  - rdy[k] = ~valid_q[k] | rdy[k+1].
  - in_ready_o = rdy[0].
- Upstream of stage k: stage k-1, or the input port for k=0.
- Stage update, when rdy[k]=1:
  - valid_q[k] <= upstream valid.
  - data_q[k] <= upstream data, only if upstream valid; otherwise data holds.
- When rdy[k]=0, the stage holds valid and data.
- Handshakes:
  - Input transfer when in_valid_i & in_ready_o.
  - Output transfer when out_valid_o & out_ready_i.
  - in_ready_o may depend combinationally on out_ready_i.
  - in_valid_i does not depend on in_ready_o.
- Latency: with no stalls, a word accepted at edge N appears at out_valid_o after edge N+DEPTH-1, i.e. it is presented for DEPTH cycles counting the accept cycle's edge as the first. Throughput is 1 word/cycle.
- Capacity: DEPTH words. With out_ready_i=0, in_ready_o deasserts once all stages are valid.
- Ordering: strict FIFO; words are never duplicated or dropped except by flush/reset.
- Upstream contract: in_data_i must be held stable while in_valid_i=1 and in_ready_o=0. Assertion: out_data_o stable while out_valid_o & ~out_ready_i.
- count_o:
  - Registered counter: +1 on input transfer, -1 on output transfer, unchanged when both or neither occur.
  - Always equals popcount(valid_q).
  - Never exceeds DEPTH; never underflows.
- Flush (flush_i=1):
  - At the next edge, all valid_q <= 0 and count_o <= 0.
  - A word presented at the input in that cycle is discarded, even though in_ready_o may read 1.
  - An output transfer in that same cycle counts as delivered.
  - Data flops hold.
- Reset:
  - Priority: reset > flush > normal.
  - At the edge with reset=1: all valid_q = 0, count_o = 0, in_ready_o = 1 (comb), out_valid_o = 0.
  - Data flops: 0 if RST_DATA=1, hold/unknown if RST_DATA=0.
  - Mid-operation reset discards all in-flight words.
- DEPTH=1: degenerates to a single registered stage with combinational ready pass-through; the same rules apply.

Test Plan:
- Latency, DEPTH=3, out_ready_i=1: drive 0xA5 for one cycle -> out_valid_o=1 with out_data_o=0xA5 exactly 3 edges after acceptance, count_o returns to 0 afterwards.
- Streaming: 8 back-to-back words 0x01..0x08, out_ready_i=1 -> in_ready_o constantly 1; outputs 0x01..0x08 on consecutive cycles; count_o steady at 3 mid-stream.
- Backpressure: out_ready_i=0, push 0x10,0x11,0x12,0x13 -> first three accepted, in_ready_o=0 while 0x13 waits, count_o=3; raise out_ready_i -> output 0x10,0x11,0x12,0x13 in order, count_o reaches 0.
- Bubble collapse: push 0x20, idle 2 cycles, push 0x21, with out_ready_i=0 throughout -> 0x20 reaches stage 2 and 0x21 stage 1; next push 0x22 accepted (count_o=3), following push refused.
- Flush: 3 words held, assert flush_i with in_valid_i=1 (0x30) -> next cycle out_valid_o=0, count_o=0, 0x30 never appears at the output.
- Reset mid-operation, RST_DATA=1: 2 words held, pulse reset -> next cycle out_valid_o=0, out_data_o=0, count_o=0, in_ready_o=1. Rerun with RST_DATA=0: valid/count identical, data unchecked.

Source files
------------

// File: rtl/elastic_pipe_reg.sv
// Elastic DEPTH-stage register slice with valid/ready on both sides.
// Empty stages always accept, so bubbles collapse while the output is stalled.
module elastic_pipe_reg #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 3,
  parameter bit RST_DATA = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] up_valid;
  logic [WIDTH-1:0] up_data [DEPTH];
  logic             acc;
  logic             in_fire, out_fire;

  // Each stage is fed by its predecessor; stage 0 by the input port.
  for (genvar k = 0; k < DEPTH; k++) begin : g_up
    if (k == 0) begin : g_first
      assign up_valid[k] = in_valid_i;
      assign up_data[k]  = in_data_i;
    end else begin : g_rest
      assign up_valid[k] = valid_q[k-1];
      assign up_data[k]  = data_q[k-1];
    end
  end

  // Ready ripples from the output back toward the input.
  always_comb begin
    rdy = '0;
    acc = out_ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc    = acc | ~valid_q[k];
      rdy[k] = acc;
    end
  end

  assign in_ready_o  = rdy[0];
  assign out_valid_o = valid_q[DEPTH-1];
  assign out_data_o  = data_q[DEPTH-1];
  assign count_o     = count_q;
  assign in_fire     = in_valid_i & rdy[0];
  assign out_fire    = valid_q[DEPTH-1] & out_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (rdy[k]) begin
        valid_d[k] = up_valid[k];
        if (up_valid[k] && !flush_i) data_d[k] = up_data[k];
      end
    end
    if (flush_i) begin
      valid_d = '0;
      count_d = '0;
    end else begin
      count_d = count_q + CW'(in_fire) - CW'(out_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Data flops only see reset when RST_DATA is set.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (RST_DATA && reset) data_q[k] <= '0;
      else                   data_q[k] <= data_d[k];
    end
  end

  a_out_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid_o && !out_ready_i) |=> (out_data_o == $past(out_data_o)));

  a_count_pop: assert property (@(posedge clk) disable iff (reset)
    count_q == CW'($countones(valid_q)));

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed bench for elastic_pipe_reg: driver queues expected words,
// a negedge monitor pops and compares on every output transfer.
module tb_elastic_pipe_reg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset, flush_i, in_valid_i, out_ready_i;
  logic [WIDTH-1:0] in_data_i;
  logic             in_ready_o, out_valid_o;
  logic [WIDTH-1:0] out_data_o;
  logic [CW-1:0]    count_o;
  logic             in_ready_2, out_valid_2;
  logic [WIDTH-1:0] out_data_2;
  logic [CW-1:0]    count_2;

  int vec  = 0;
  int errs = 0;
  logic [WIDTH-1:0] exp_q [$];

  always #5 clk = ~clk;

  elastic_pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_DATA(1'b1)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .count_o(count_o)
  );

  elastic_pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_DATA(1'b0)) dut_nr (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_2), .in_data_i(in_data_i),
    .out_valid_o(out_valid_2), .out_ready_i(out_ready_i), .out_data_o(out_data_2),
    .count_o(count_2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d);
    in_valid_i = v;
    in_data_i  = d;
    #1;
  endtask

  // Scoreboard monitor: an output transfer happens at the next posedge.
  always @(negedge clk) begin
    if (!reset && out_valid_o && out_ready_i) begin
      vec++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL out_word: got 0x%0h, expected no word at %0t", out_data_o, $time);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (out_data_o !== e) begin
          errs++;
          $display("FAIL out_word: got 0x%0h, expected 0x%0h at %0t", out_data_o, e, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_count", count_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_out_data", out_data_o, 0);

    // Latency
    out_ready_i = 1'b1;
    exp_q.push_back(8'hA5);
    drive(1'b1, 8'hA5);
    tick();
    drive(1'b0, 8'h00);
    chk("lat_e0_valid", out_valid_o, 0);
    chk("lat_e0_count", count_o, 1);
    tick();
    chk("lat_e1_valid", out_valid_o, 0);
    tick();
    chk("lat_e2_valid", out_valid_o, 1);
    chk("lat_e2_data", out_data_o, 8'hA5);
    chk("lat_e2_count", count_o, 1);
    tick();
    chk("lat_e3_valid", out_valid_o, 0);
    chk("lat_e3_count", count_o, 0);

    // Streaming
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(WIDTH'(i));
      drive(1'b1, WIDTH'(i));
      chk("stream_in_ready", in_ready_o, 1);
      tick();
      if (i >= 3) begin
        chk("stream_count", count_o, 3);
        chk("stream_out_valid", out_valid_o, 1);
      end
    end
    drive(1'b0, 8'h00);
    tick(); tick(); tick();
    chk("stream_drained", count_o, 0);

    // Backpressure
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h10 + WIDTH'(i));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h10 + WIDTH'(i));
      chk("bp_accept_ready", in_ready_o, 1);
      tick();
    end
    drive(1'b1, 8'h13);
    chk("bp_full_ready", in_ready_o, 0);
    chk("bp_full_count", count_o, 3);
    tick();
    chk("bp_hold_count", count_o, 3);
    out_ready_i = 1'b1;
    #1;
    chk("bp_release_ready", in_ready_o, 1);
    tick();
    drive(1'b0, 8'h00);
    chk("bp_swap_count", count_o, 3);
    tick(); tick(); tick();
    chk("bp_drained", count_o, 0);
    chk("bp_drained_valid", out_valid_o, 0);

    // Bubble collapse
    out_ready_i = 1'b0;
    exp_q.push_back(8'h20); exp_q.push_back(8'h21); exp_q.push_back(8'h22);
    drive(1'b1, 8'h20); tick();
    drive(1'b0, 8'h00); tick(); tick();
    chk("bub_head_valid", out_valid_o, 1);
    chk("bub_head_data", out_data_o, 8'h20);
    drive(1'b1, 8'h21); tick();
    chk("bub_count2", count_o, 2);
    drive(1'b1, 8'h22);
    chk("bub_accept_ready", in_ready_o, 1);
    tick();
    chk("bub_count3", count_o, 3);
    drive(1'b1, 8'h23);
    chk("bub_refuse_ready", in_ready_o, 0);
    tick();
    chk("bub_refuse_count", count_o, 3);
    drive(1'b0, 8'h00);
    out_ready_i = 1'b1;
    tick(); tick(); tick();
    chk("bub_drained", count_o, 0);

    // Flush: held words and the concurrently offered 0x30 are discarded
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h40 + WIDTH'(i));
      tick();
    end
    drive(1'b0, 8'h00);
    chk("fl_pre_count", count_o, 3);
    flush_i = 1'b1;
    drive(1'b1, 8'h30);
    tick();
    flush_i = 1'b0;
    drive(1'b0, 8'h00);
    chk("fl_out_valid", out_valid_o, 0);
    chk("fl_count", count_o, 0);
    chk("fl_in_ready", in_ready_o, 1);
    out_ready_i = 1'b1;
    tick(); tick(); tick();
    chk("fl_stays_empty", out_valid_o, 0);

    // Reset mid-operation, both data-reset flavours
    out_ready_i = 1'b0;
    drive(1'b1, 8'h50); tick();
    drive(1'b1, 8'h51); tick();
    drive(1'b0, 8'h00); tick();
    chk("rm_pre_valid", out_valid_o, 1);
    chk("rm_pre_data", out_data_o, 8'h50);
    chk("rm_pre_count", count_o, 2);
    chk("rm_pre_count_nr", count_2, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rm_out_valid", out_valid_o, 0);
    chk("rm_out_data", out_data_o, 0);
    chk("rm_count", count_o, 0);
    chk("rm_in_ready", in_ready_o, 1);
    chk("rm_out_valid_nr", out_valid_2, 0);
    chk("rm_count_nr", count_2, 0);
    chk("rm_in_ready_nr", in_ready_2, 1);

    // Recovery after reset
    out_ready_i = 1'b1;
    exp_q.push_back(8'h60);
    drive(1'b1, 8'h60); tick();
    drive(1'b0, 8'h00);
    tick(); tick(); tick();
    chk("end_count", count_o, 0);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
